// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts stalled ACCESS cycles and flags expiry on the
// TIMEOUT_CYCLES-th stalled cycle. Used only with DATA_MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Counter is held at zero outside ACCESS, so it starts clean on every entry.
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            cnt <= '0;
        end else if (!ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry on the last allowed stalled cycle; a same-cycle ready wins in the FSM.
    always_comb begin
        expired = active && !ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester (CPU / debug) round-robin arbiter and access sequencer for the
// shared data memory port. Optional watchdog abort: DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    input  logic              m_error,
    output logic              busy,
    output logic              owner,
    output logic              timeout
);

    arb_state_t        state, state_nx;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              owner_q;
    logic              last_grant;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              err_q;
    logic              timeout_q;
    logic              winner;
    logic              in_access;
    logic              expired;

    assign in_access = (state == ACCESS);

`ifdef DATA_MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (in_access),
        .ready  (m_ready),
        .expired(expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    // Round-robin pick: a lone requester wins, on contention the one not granted last.
    always_comb begin
        if (cpu_req && dbg_req) begin
            winner = ~last_grant;
        end else if (dbg_req) begin
            winner = OWNER_DBG;
        end else begin
            winner = OWNER_CPU;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; DONE always returns to IDLE so no re-grant on the ack cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req || dbg_req) state_nx = ACCESS;
            ACCESS:  if (m_ready || expired) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command latch on grant, response capture on completion or watchdog abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            owner_q     <= OWNER_CPU;
            last_grant  <= OWNER_DBG;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == IDLE && (cpu_req || dbg_req)) begin
                cmd_we     <= winner ? dbg_we    : cpu_we;
                cmd_addr   <= winner ? dbg_addr  : cpu_addr;
                cmd_wdata  <= winner ? dbg_wdata : cpu_wdata;
                owner_q    <= winner;
                last_grant <= winner;
            end
            if (in_access) begin
                if (m_ready) begin
                    if (owner_q == OWNER_DBG) dbg_rdata_q <= m_rdata;
                    else                      cpu_rdata_q <= m_rdata;
                    err_q <= m_error;
                end else if (expired) begin
                    if (owner_q == OWNER_DBG) dbg_rdata_q <= '0;
                    else                      cpu_rdata_q <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Output decode from state and latched registers.
    always_comb begin
        busy      = (state != IDLE);
        m_valid   = in_access;
        m_we      = in_access & cmd_we;
        m_addr    = cmd_addr;
        m_wdata   = cmd_wdata;
        owner     = owner_q;
        cpu_ack   = (state == DONE) && (owner_q == OWNER_CPU);
        dbg_ack   = (state == DONE) && (owner_q == OWNER_DBG);
        cpu_err   = cpu_ack & err_q;
        dbg_err   = dbg_ack & err_q;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_data_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, m_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, m_wdata, m_rdata;
    logic          cpu_ack, cpu_err, dbg_ack, dbg_err;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          m_valid, m_we, m_ready, m_error;
    logic          busy, owner, timeout;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
        .busy(busy), .owner(owner), .timeout(timeout)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is idle -> in flight -> acknowledged.
    int            ph;
    logic          own, last, we_l, err_l, tmo;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l, rd_cpu, rd_dbg;
    int unsigned   stall_n;

    always @(posedge clk) begin
        logic win;
        if (rst) begin
            ph = 0; own = 1'b0; last = 1'b1; we_l = 1'b0; err_l = 1'b0; tmo = 1'b0;
            addr_l = '0; wdata_l = '0; rd_cpu = '0; rd_dbg = '0; stall_n = 0;
        end else begin
            tmo = 1'b0;
            case (ph)
                0: if (cpu_req || dbg_req) begin
                    win     = (cpu_req && dbg_req) ? !last : dbg_req;
                    own     = win;
                    last    = win;
                    we_l    = win ? dbg_we : cpu_we;
                    addr_l  = win ? dbg_addr : cpu_addr;
                    wdata_l = win ? dbg_wdata : cpu_wdata;
                    stall_n = 0;
                    ph      = 1;
                end
                1: if (m_ready) begin
                    if (own) rd_dbg = m_rdata; else rd_cpu = m_rdata;
                    err_l = m_error;
                    ph    = 2;
                end else begin
                    stall_n++;
                    if (WD_EN && stall_n == TO) begin
                        if (own) rd_dbg = '0; else rd_cpu = '0;
                        err_l = 1'b1;
                        tmo   = 1'b1;
                        ph    = 2;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy",      busy,      ph != 0);
            chk("cmp_owner",     owner,     own);
            chk("cmp_m_valid",   m_valid,   ph == 1);
            chk("cmp_m_we",      m_we,      (ph == 1) && we_l);
            chk("cmp_m_addr",    m_addr,    addr_l);
            chk("cmp_m_wdata",   m_wdata,   wdata_l);
            chk("cmp_cpu_ack",   cpu_ack,   (ph == 2) && !own);
            chk("cmp_dbg_ack",   dbg_ack,   (ph == 2) && own);
            chk("cmp_cpu_err",   cpu_err,   (ph == 2) && !own && err_l);
            chk("cmp_dbg_err",   dbg_err,   (ph == 2) && own && err_l);
            chk("cmp_cpu_rdata", cpu_rdata, rd_cpu);
            chk("cmp_dbg_rdata", dbg_rdata, rd_dbg);
            chk("cmp_timeout",   timeout,   tmo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit dbg, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((dbg ? dbg_ack : cpu_ack) === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int   n;
        int   vcnt;
        bit   seen;
        int   cpu_t[$];
        int   dbg_t[$];

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        m_rdata = '0; m_ready = 1'b1; m_error = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        rst = 1'b0;
        tick();

        // CPU read alone, minimum latency
        cpu_addr = 32'h14; m_rdata = 32'h11; cpu_req = 1'b1;
        tick();
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_addr", m_addr, 32'h14);
        tick();
        chk("t1_cpu_ack", cpu_ack, 1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h11);
        chk("t1_cpu_err", cpu_err, 0);
        chk("t1_dbg_ack", dbg_ack, 0);
        cpu_req = 1'b0;
        tick();
        chk("t1_ack_drop", cpu_ack, 0);

        // CPU write with 5 stall cycles; inputs scrambled mid-access
        cpu_we = 1'b1; cpu_addr = 32'h1000_0004; cpu_wdata = 32'hA5A5_0001;
        m_ready = 1'b0; cpu_req = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_valid && m_we && m_addr == 32'h1000_0004 && m_wdata == 32'hA5A5_0001) vcnt++;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_we    = 1'($urandom);
            if (i == 5) m_ready = 1'b1;
        end
        tick();
        chk("t2_stable_cycles", vcnt, 6);
        chk("t2_cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        // Debug access with error, then a clean access
        dbg_addr = 32'h4000_0000; m_error = 1'b1; m_rdata = 32'hDEAD_BEEF; dbg_req = 1'b1;
        wait_ack(1'b1, 10, n);
        chk("t4_latency", n, 2);
        chk("t4_dbg_err", dbg_err, 1);
        chk("t4_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        chk("t4_cpu_ack", cpu_ack, 0);
        dbg_req = 1'b0; m_error = 1'b0;
        tick();
        chk("t4_err_outside_ack", dbg_err, 0);
        m_rdata = 32'h22; dbg_req = 1'b1;
        wait_ack(1'b1, 10, n);
        chk("t4b_latency", n, 2);
        chk("t4b_dbg_err", dbg_err, 0);
        chk("t4b_dbg_rdata", dbg_rdata, 32'h22);
        dbg_req = 1'b0;
        tick();

        // Reset during ACCESS
        cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h55; m_ready = 1'b0; cpu_req = 1'b1;
        tick();
        tick();
        chk("t5_in_access", m_valid, 1);
        rst = 1'b1;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_no_ack", {cpu_ack, dbg_ack}, 2'b00);
        rst = 1'b0; cpu_req = 1'b0; m_ready = 1'b1; cpu_we = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (cpu_ack || dbg_ack) seen = 1'b1;
        end
        chk("t5_dropped", seen, 0);
        cpu_addr = 32'h20; m_rdata = 32'h33; cpu_req = 1'b1;
        wait_ack(1'b0, 10, n);
        chk("t5_after_latency", n, 2);
        chk("t5_after_rdata", cpu_rdata, 32'h33);
        cpu_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Contention, both held: grants alternate, CPU first after reset
        cpu_addr = 32'h100; dbg_addr = 32'h200; m_rdata = 32'h44;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cpu_ack) cpu_t.push_back(i);
            if (dbg_ack) dbg_t.push_back(i);
            if (i == 11) begin
                cpu_req = 1'b0; dbg_req = 1'b0;
            end
        end
        chk("t3_cpu_count", cpu_t.size(), 2);
        chk("t3_dbg_count", dbg_t.size(), 2);
        if (cpu_t.size() == 2 && dbg_t.size() == 2) begin
            chk("t3_cpu_ack0", cpu_t[0], 2);
            chk("t3_dbg_ack0", dbg_t[0], 5);
            chk("t3_cpu_ack1", cpu_t[1], 8);
            chk("t3_dbg_ack1", dbg_t[1], 11);
        end
        tick();

`ifdef DATA_MEM_ARB_TIMEOUT_EN
        // Watchdog abort after TO stalled cycles
        dbg_addr = 32'h2000_0000; m_rdata = 32'h99; m_ready = 1'b0; dbg_req = 1'b1;
        wait_ack(1'b1, 20, n);
        chk("t6_latency", n, 9);
        chk("t6_dbg_err", dbg_err, 1);
        chk("t6_dbg_rdata", dbg_rdata, 0);
        chk("t6_timeout", timeout, 1);
        dbg_req = 1'b0;
        tick();
        chk("t6_timeout_pulse", timeout, 0);
        tick();
        // Ready on the expiry cycle completes normally
        dbg_req = 1'b1;
        repeat (8) tick();
        m_ready = 1'b1;
        tick();
        chk("t7_dbg_ack", dbg_ack, 1);
        chk("t7_dbg_err", dbg_err, 0);
        chk("t7_timeout", timeout, 0);
        chk("t7_dbg_rdata", dbg_rdata, 32'h99);
        dbg_req = 1'b0;
        tick();
`else
        // Without the watchdog a stalled access waits indefinitely
        cpu_addr = 32'h300; m_rdata = 32'h77; m_ready = 1'b0; cpu_req = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (cpu_ack || dbg_ack || timeout) seen = 1'b1;
        end
        chk("t6_no_abort", seen, 0);
        chk("t6_still_valid", m_valid, 1);
        m_ready = 1'b1;
        tick();
        chk("t6_cpu_ack", cpu_ack, 1);
        chk("t6_cpu_rdata", cpu_rdata, 32'h77);
        cpu_req = 1'b0;
        tick();
`endif

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
